exe_stage: RTL and testbench

//  Execute stage of the 5-stage RV32 pipeline: registers the decode->execute bus, computes ALU results,

---
 rtl/exe_stage.sv | 186 ++++++++++++++++++
 tb/tb_exe_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage of the RV32 pipeline: input register, single-cycle ALU, optional iterative RV32M unit.
// Define EXE_MULDIV_EN to build the 32-iteration multiply/divide FSM; otherwise ops 16-23 yield 0.
module exe_stage #(
    parameter int XLEN  = 32,
    parameter int IN_W  = 112,
    parameter int OUT_W = 75
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [IN_W-1:0]  id_exe_bus_in,
    input  logic             flush,
    output logic             exe_ready,
    output logic             exe_busy,
    output logic [OUT_W-1:0] exe_mem_bus_out
);
    localparam int META_W = OUT_W - XLEN;

    logic [XLEN-1:0]   in_op1, in_op2;
    logic [4:0]        in_op;
    logic [META_W-1:0] in_meta;
    logic              cap;

    logic [XLEN-1:0]   op1_p1, op2_p1;
    logic [4:0]        op_p1;
    logic [META_W-1:0] meta_p1;
    logic              vld_p1;
    logic [XLEN-1:0]   alu_res;

    assign in_op1  = id_exe_bus_in[111:80];
    assign in_op2  = id_exe_bus_in[79:48];
    assign in_op   = id_exe_bus_in[47:43];
    assign in_meta = id_exe_bus_in[42:0];
    assign cap     = id_valid & exe_ready & ~flush;

    // ---- p0 -> p1: decode bus capture ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            op1_p1  <= '0;
            op2_p1  <= '0;
            op_p1   <= '0;
            meta_p1 <= '0;
        end else begin
            vld_p1 <= cap;
            if (cap) begin
                op1_p1  <= in_op1;
                op2_p1  <= in_op2;
                op_p1   <= in_op;
                meta_p1 <= in_meta;
            end
        end
    end

    logic signed [XLEN-1:0] op1_s, op2_s;
    assign op1_s = op1_p1;
    assign op2_s = op2_p1;

    always_comb begin
        alu_res = '0;
        case (op_p1)
            5'd0:    alu_res = op1_p1 + op2_p1;
            5'd1:    alu_res = op1_p1 - op2_p1;
            5'd2:    alu_res = op1_p1 & op2_p1;
            5'd3:    alu_res = op1_p1 | op2_p1;
            5'd4:    alu_res = op1_p1 ^ op2_p1;
            5'd5:    alu_res = op1_p1 << op2_p1[4:0];
            5'd6:    alu_res = op1_p1 >> op2_p1[4:0];
            5'd7:    alu_res = op1_s >>> op2_p1[4:0];
            5'd8:    alu_res = {31'b0, op1_s < op2_s};
            5'd9:    alu_res = {31'b0, op1_p1 < op2_p1};
            5'd10:   alu_res = op2_p1;
            default: alu_res = '0;
        endcase
    end

`ifdef EXE_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [4:0]      cnt;
    logic [XLEN-1:0] a_p2, b_p2, res_p2, fin;
    logic [63:0]     acc_p2, mul_acc, prod_fix;
    logic [32:0]     mul_sum, r33;
    logic [XLEN-1:0] mul_a, div_a, div_hi, quo_fix, rem_fix;
    logic            start, ge, s1, s2, div0;

    function automatic logic op1_signed(input logic [4:0] op);
        return (op == 5'd16) || (op == 5'd17) || (op == 5'd18) || (op == 5'd20) || (op == 5'd22);
    endfunction

    function automatic logic op2_signed(input logic [4:0] op);
        return (op == 5'd16) || (op == 5'd17) || (op == 5'd20) || (op == 5'd22);
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    assign start = cap & (in_op[4:3] == 2'b10);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // One shift-add step (right-shifting product) and one restoring-divide step per BUSY cycle
    always_comb begin
        mul_sum = {1'b0, acc_p2[63:32]} + {1'b0, (a_p2[0] ? b_p2 : '0)};
        mul_acc = {mul_sum, acc_p2[31:1]};
        mul_a   = a_p2 >> 1;
        r33     = {acc_p2[63:32], a_p2[XLEN-1]};
        ge      = r33 >= {1'b0, b_p2};
        div_hi  = ge ? 32'(r33 - {1'b0, b_p2}) : r33[31:0];
        div_a   = {a_p2[XLEN-2:0], ge};
    end

    // Sign fix-up applied to the values produced by the final iteration
    always_comb begin
        s1       = op1_signed(op_p1) & op1_p1[XLEN-1];
        s2       = op2_signed(op_p1) & op2_p1[XLEN-1];
        div0     = (op2_p1 == '0);
        prod_fix = (s1 ^ s2) ? -mul_acc : mul_acc;
        quo_fix  = (s1 ^ s2) ? -div_a : div_a;
        rem_fix  = s1 ? -div_hi : div_hi;
        case (op_p1[2:0])
            3'd0:       fin = prod_fix[31:0];
            3'd1, 3'd2,
            3'd3:       fin = prod_fix[63:32];
            3'd4, 3'd5: fin = div0 ? '1 : quo_fix;
            default:    fin = div0 ? op1_p1 : rem_fix;
        endcase
    end

    // ---- p1 -> p2: iterative RV32M unit ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            res_p2 <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt <= '0;
            end else if (start) begin
                cnt <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) res_p2 <= fin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            a_p2   <= mag(in_op1, op1_signed(in_op));
            b_p2   <= mag(in_op2, op2_signed(in_op));
            acc_p2 <= '0;
        end else if (state == BUSY) begin
            a_p2   <= op_p1[2] ? div_a : mul_a;
            acc_p2 <= op_p1[2] ? {div_hi, 32'b0} : mul_acc;
        end
    end

    assign exe_busy  = (state == BUSY);
    assign exe_ready = ~exe_busy;

    always_comb begin
        exe_mem_bus_out = '0;
        if (state == DONE)
            exe_mem_bus_out = {res_p2, meta_p1};
        else if (vld_p1 && state == IDLE)
            exe_mem_bus_out = {alu_res, meta_p1};
    end
`else
    assign exe_busy        = 1'b0;
    assign exe_ready       = 1'b1;
    assign exe_mem_bus_out = vld_p1 ? {alu_res, meta_p1} : '0;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU vector table plus multi-cycle M-op, flush and reset sequences.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         rst, id_valid, flush;
    logic [111:0] bus_in;
    logic         exe_ready, exe_busy;
    logic [74:0]  bus_out;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_exe_bus_in(bus_in), .flush(flush),
        .exe_ready(exe_ready), .exe_busy(exe_busy), .exe_mem_bus_out(bus_out)
    );

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [111:0] mk_in(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                           logic [4:0] rd, logic [31:0] pc);
        return {a, b, op, rd, 1'b1, 1'b0, 1'b0, 3'b001, pc};
    endfunction

    function automatic logic [74:0] mk_out(logic [31:0] r, logic [4:0] rd, logic [31:0] pc);
        return {r, rd, 1'b1, 1'b0, 1'b0, 3'b001, pc};
    endfunction

    task automatic check(string name, logic [74:0] got, logic [74:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one M op and verify 32 stall cycles followed by the result on cycle 33
    task automatic run_mop(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
        int bad = 0;
        @(negedge clk);
        id_valid = 1'b1;
        bus_in   = mk_in(op, a, b, 5'd5, 32'h2000);
        @(negedge clk);
        id_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (exe_ready !== 1'b0 || exe_busy !== 1'b1 || bus_out !== '0) bad++;
            @(negedge clk);
        end
        check({name, "_stall"}, 75'(bad), 75'd0);
        check({name, "_result"}, bus_out, mk_out(exp, 5'd5, 32'h2000));
        check({name, "_ready"}, 75'(exe_ready), 75'd1);
        @(negedge clk);
        check({name, "_bubble"}, bus_out, 75'd0);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0; bus_in = '0;
        repeat (2) @(negedge clk);
        check("rst_bus", bus_out, 75'd0);
        check("rst_ready", 75'(exe_ready), 75'd1);
        check("rst_busy", 75'(exe_busy), 75'd0);
        rst = 1'b0;

        vecs.push_back('{"add",      5'd0,  32'd5,         32'd7,         5'd3, 32'd12});
        vecs.push_back('{"sub",      5'd1,  32'd5,         32'd7,         5'd4, 32'hFFFF_FFFE});
        vecs.push_back('{"and",      5'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd5, 32'h00F0_00F0});
        vecs.push_back('{"or",       5'd3,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 32'hFFF0_FFF0});
        vecs.push_back('{"xor",      5'd4,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7, 32'hFF00_FF00});
        vecs.push_back('{"sll31",    5'd5,  32'd1,         32'd31,        5'd8, 32'h8000_0000});
        vecs.push_back('{"sll_mask", 5'd5,  32'd1,         32'h25,        5'd9, 32'h20});
        vecs.push_back('{"srl",      5'd6,  32'h8000_0000, 32'd4,         5'd10, 32'h0800_0000});
        vecs.push_back('{"sra",      5'd7,  32'h8000_0000, 32'd4,         5'd11, 32'hF800_0000});
        vecs.push_back('{"slt_t",    5'd8,  32'hFFFF_FFFF, 32'd1,         5'd12, 32'd1});
        vecs.push_back('{"slt_f",    5'd8,  32'd1,         32'hFFFF_FFFF, 5'd13, 32'd0});
        vecs.push_back('{"sltu_t",   5'd9,  32'd1,         32'hFFFF_FFFF, 5'd14, 32'd1});
        vecs.push_back('{"sltu_f",   5'd9,  32'hFFFF_FFFF, 32'd1,         5'd15, 32'd0});
        vecs.push_back('{"pass_x0",  5'd10, 32'd123,       32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF});
        vecs.push_back('{"bad11",    5'd11, 32'd9,         32'd9,         5'd16, 32'd0});
        vecs.push_back('{"bad31",    5'd31, 32'd9,         32'd9,         5'd17, 32'd0});
`ifndef EXE_MULDIV_EN
        vecs.push_back('{"mul_off",  5'd16, 32'd3,         32'd4,         5'd18, 32'd0});
        vecs.push_back('{"div_off",  5'd20, 32'd8,         32'd2,         5'd19, 32'd0});
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            id_valid = 1'b1;
            bus_in   = mk_in(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 32'h1000 + 32'(4 * i));
            @(negedge clk);
            check(vecs[i].name, bus_out, mk_out(vecs[i].exp, vecs[i].rd, 32'h1000 + 32'(4 * i)));
            check({vecs[i].name, "_rdy"}, 75'(exe_ready), 75'd1);
        end
        id_valid = 1'b0;
        @(negedge clk);
        check("idle_bubble", bus_out, 75'd0);

        // flush on the capture edge suppresses the instruction
        id_valid = 1'b1; flush = 1'b1;
        bus_in = mk_in(5'd0, 32'd1, 32'd1, 5'd2, 32'h3000);
        @(negedge clk);
        id_valid = 1'b0; flush = 1'b0;
        check("flush_capture", bus_out, 75'd0);

`ifdef EXE_MULDIV_EN
        run_mop("mulh",   5'd17, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF);
        run_mop("mul",    5'd16, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB);
        run_mop("mulhu",  5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_mop("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
        run_mop("div0",   5'd20, 32'd7,         32'd0,         32'hFFFF_FFFF);
        run_mop("rem0",   5'd22, 32'd7,         32'd0,         32'd7);
        run_mop("divovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_mop("removf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_mop("remu",   5'd23, 32'd100,       32'd7,         32'd2);
        run_mop("divneg", 5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_mop("remneg", 5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);

        // flush at BUSY cycle 10 kills the divide for good
        begin
            int bad = 0;
            id_valid = 1'b1;
            bus_in   = mk_in(5'd20, 32'd1000, 32'd3, 5'd6, 32'h4000);
            @(negedge clk);
            id_valid = 1'b0;
            repeat (10) @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check("flush_ready", 75'(exe_ready), 75'd1);
            check("flush_busy", 75'(exe_busy), 75'd0);
            check("flush_bus", bus_out, 75'd0);
            repeat (40) begin
                if (bus_out !== '0 || exe_ready !== 1'b1) bad++;
                @(negedge clk);
            end
            check("flush_no_result", 75'(bad), 75'd0);
        end

        // reset mid-BUSY discards the in-flight op
        begin
            int bad = 0;
            id_valid = 1'b1;
            bus_in   = mk_in(5'd16, 32'd3, 32'd4, 5'd6, 32'h5000);
            @(negedge clk);
            id_valid = 1'b0;
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rstbusy_ready", 75'(exe_ready), 75'd1);
            check("rstbusy_bus", bus_out, 75'd0);
            repeat (40) begin
                if (bus_out !== '0 || exe_busy !== 1'b0) bad++;
                @(negedge clk);
            end
            check("rstbusy_no_result", 75'(bad), 75'd0);
        end

        // ADD captured on the DONE edge follows DIVU with no gap
        id_valid = 1'b1;
        bus_in   = mk_in(5'd21, 32'd100, 32'd7, 5'd7, 32'h6000);
        @(negedge clk);
        id_valid = 1'b0;
        repeat (32) @(negedge clk);
        check("b2b_divu", bus_out, mk_out(32'd14, 5'd7, 32'h6000));
        id_valid = 1'b1;
        bus_in   = mk_in(5'd0, 32'd5, 32'd7, 5'd9, 32'h6004);
        @(negedge clk);
        id_valid = 1'b0;
        check("b2b_add", bus_out, mk_out(32'd12, 5'd9, 32'h6004));
        @(negedge clk);
        check("b2b_bubble", bus_out, 75'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
